// File: rtl/stepper_drive_ctrl.sv
// Unipolar stepper sequencer: wave/half-step phase table, programmable step period,
// continuous or counted moves with Busy/Done, signed half-step position counter.
module stepper_drive_ctrl #(
    parameter int DIV_WIDTH = 24,
    parameter int CNT_WIDTH = 16,
    parameter int POS_WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        Reset,
    input  logic                        Direction,
    input  logic                        HalfStep,
    input  logic                        Hold,
    input  logic [DIV_WIDTH-1:0]        Divider,
    input  logic                        StepEnable,
    input  logic                        Start,
    input  logic [CNT_WIDTH-1:0]        StepCount,
    input  logic                        Abort,
    output logic [3:0]                  StepDrive,
    output logic                        Busy,
    output logic                        Done,
    output logic signed [POS_WIDTH-1:0] Position
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN_CONT  = 2'd1,
        S_RUN_COUNT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DIV_WIDTH-1:0]  per_q, per_d;
    logic [3:0]            drive_q, drive_d;
    logic                  done_q, done_d;
    logic [POS_WIDTH-1:0]  pos_q, pos_d;

    logic [DIV_WIDTH-1:0]  div_eff;
    logic                  tick;
    logic                  step;
    logic [2:0]            idx_step;
    logic [POS_WIDTH-1:0]  pos_step;

    function automatic logic [3:0] phase(input logic [2:0] i);
        case (i)
            3'd0:    phase = 4'b0001;
            3'd1:    phase = 4'b0011;
            3'd2:    phase = 4'b0010;
            3'd3:    phase = 4'b0110;
            3'd4:    phase = 4'b0100;
            3'd5:    phase = 4'b1100;
            3'd6:    phase = 4'b1000;
            default: phase = 4'b1001;
        endcase
    endfunction

    assign div_eff = (Divider < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : Divider;
    // The period in force is latched at motion start and at each tick, so a
    // Divider change never truncates the period already running.
    assign tick    = (div_q == per_q - DIV_WIDTH'(1));

    always_comb begin
        idx_step = idx_q;
        pos_step = pos_q;
        case ({HalfStep, Direction})
            2'b11: begin
                idx_step = idx_q + 3'd1;
                pos_step = pos_q + POS_WIDTH'(1);
            end
            2'b10: begin
                idx_step = idx_q - 3'd1;
                pos_step = pos_q - POS_WIDTH'(1);
            end
            2'b01: begin
                idx_step = {idx_q[2:1], 1'b0} + 3'd2;
                pos_step = pos_q + POS_WIDTH'(2);
            end
            default: begin
                idx_step = ((idx_q + 3'd1) & 3'b110) - 3'd2;
                pos_step = pos_q - POS_WIDTH'(2);
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        div_d   = div_q;
        per_d   = per_q;
        pos_d   = pos_q;
        done_d  = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (Abort) begin
                    state_d = S_IDLE;
                end else if (Start) begin
                    if (StepCount == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN_COUNT;
                        rem_d   = StepCount;
                        per_d   = div_eff;
                    end
                end else if (StepEnable) begin
                    state_d = S_RUN_CONT;
                    per_d   = div_eff;
                end
            end
            S_RUN_CONT: begin
                if (Abort || !StepEnable) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else if (tick) begin
                    step  = 1'b1;
                    div_d = '0;
                    per_d = div_eff;
                end else begin
                    div_d = div_q + DIV_WIDTH'(1);
                end
            end
            S_RUN_COUNT: begin
                if (Abort) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else if (tick) begin
                    step  = 1'b1;
                    div_d = '0;
                    per_d = div_eff;
                    rem_d = rem_q - CNT_WIDTH'(1);
                    if (rem_q == CNT_WIDTH'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
        endcase
        if (step) begin
            idx_d = idx_step;
            pos_d = pos_step;
        end
        drive_d = ((state_d != S_IDLE) || Hold) ? phase(idx_d) : 4'b0000;
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            per_q   <= '0;
            drive_q <= 4'b0000;
            done_q  <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            per_q   <= per_d;
            drive_q <= drive_d;
            done_q  <= done_d;
            pos_q   <= pos_d;
        end
    end

    assign StepDrive = drive_q;
    assign Busy      = (state_q == S_RUN_COUNT);
    assign Done      = done_q;
    assign Position  = pos_q;

endmodule

// File: tb/tb_stepper_drive_ctrl.sv
// Directed bench for stepper_drive_ctrl: expected steps are queued when a move is
// launched and checked (timing, coils, position, Busy/Done) as the DUT steps.
module tb_stepper_drive_ctrl;
    localparam int DW = 24;
    localparam int CW = 16;
    localparam int PW = 8;

    logic          clock = 1'b0;
    logic          Reset;
    logic          Direction;
    logic          HalfStep;
    logic          Hold;
    logic [DW-1:0] Divider;
    logic          StepEnable;
    logic          Start;
    logic [CW-1:0] StepCount;
    logic          Abort;
    logic [3:0]    StepDrive;
    logic          Busy;
    logic          Done;
    logic [PW-1:0] Position;

    stepper_drive_ctrl #(.DIV_WIDTH(DW), .CNT_WIDTH(CW), .POS_WIDTH(PW)) dut (
        .clock      (clock),
        .Reset      (Reset),
        .Direction  (Direction),
        .HalfStep   (HalfStep),
        .Hold       (Hold),
        .Divider    (Divider),
        .StepEnable (StepEnable),
        .Start      (Start),
        .StepCount  (StepCount),
        .Abort      (Abort),
        .StepDrive  (StepDrive),
        .Busy       (Busy),
        .Done       (Done),
        .Position   (Position)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            cyc;
        logic [3:0]    drv;
        logic [PW-1:0] pos;
        logic          done;
        logic          busy;
    } exp_t;

    exp_t          sb[$];
    int            tests = 0;
    int            fails = 0;
    logic [2:0]    m_idx;
    logic [PW-1:0] m_pos;

    function automatic logic [3:0] ptab(input logic [2:0] i);
        case (i)
            3'd0:    ptab = 4'b0001;
            3'd1:    ptab = 4'b0011;
            3'd2:    ptab = 4'b0010;
            3'd3:    ptab = 4'b0110;
            3'd4:    ptab = 4'b0100;
            3'd5:    ptab = 4'b1100;
            3'd6:    ptab = 4'b1000;
            default: ptab = 4'b1001;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc1();
        @(posedge clock);
        #1;
    endtask

    task automatic m_step(input logic half, input logic dir);
        if (half) begin
            m_idx = dir ? m_idx + 3'd1 : m_idx - 3'd1;
            m_pos = dir ? m_pos + 8'd1 : m_pos - 8'd1;
        end else if (dir) begin
            m_idx = m_idx[0] ? m_idx + 3'd1 : m_idx + 3'd2;
            m_pos = m_pos + 8'd2;
        end else begin
            m_idx = m_idx[0] ? m_idx - 3'd1 : m_idx - 3'd2;
            m_pos = m_pos - 8'd2;
        end
    endtask

    task automatic push_steps(input int n, input int effd, input bit counted, input bit ends);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            m_step(HalfStep, Direction);
            e.cyc  = k * effd;
            e.drv  = ptab(m_idx);
            e.pos  = m_pos;
            e.done = ends && (k == n);
            e.busy = counted && !(ends && (k == n));
            sb.push_back(e);
        end
    endtask

    task automatic pulse_start(input logic [CW-1:0] cnt);
        StepCount = cnt;
        Start     = 1'b1;
        cyc1();
        Start     = 1'b0;
    endtask

    // Entered just after the edge that launched the move (cycle 0).
    task automatic drain(input string tag, input int budget);
        int            c;
        logic [PW-1:0] prev;
        exp_t          e;
        c    = 0;
        prev = Position;
        while (sb.size() > 0 && c < budget) begin
            cyc1();
            c++;
            if (Position !== prev) begin
                prev = Position;
                e    = sb.pop_front();
                check({tag, "_cyc"},  c,         e.cyc);
                check({tag, "_drv"},  StepDrive, e.drv);
                check({tag, "_pos"},  Position,  e.pos);
                check({tag, "_done"}, Done,      e.done);
                check({tag, "_busy"}, Busy,      e.busy);
            end else begin
                check({tag, "_nodone"}, Done, 1'b0);
            end
        end
        if (sb.size() > 0) begin
            check({tag, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset      = 1'b1;
        Hold       = 1'b1;
        Direction  = 1'b1;
        HalfStep   = 1'b1;
        Divider    = 24'd4;
        StepEnable = 1'b0;
        Start      = 1'b0;
        StepCount  = '0;
        Abort      = 1'b0;
        m_idx      = 3'd0;
        m_pos      = '0;

        repeat (3) cyc1();
        check("rst_drive", StepDrive, 4'b0000);
        check("rst_busy",  Busy,      1'b0);
        check("rst_done",  Done,      1'b0);
        check("rst_pos",   Position,  8'd0);
        Reset = 1'b0;
        cyc1();
        check("hold_drive", StepDrive, 4'b0001);
        check("idle_pos",   Position,  8'd0);
        check("idle_busy",  Busy,      1'b0);

        // Counted half-step forward, 10 steps at period 4
        HalfStep = 1'b1; Direction = 1'b1; Divider = 24'd4;
        push_steps(10, 4, 1'b1, 1'b1);
        pulse_start(16'd10);
        check("half_busy_start", Busy, 1'b1);
        drain("half_fwd", 60);
        check("half_final_pos", Position,  8'd10);
        check("half_final_drv", StepDrive, 4'b0010);
        cyc1();
        check("half_done_clr", Done, 1'b0);
        check("half_busy_clr", Busy, 1'b0);

        // One half step back to idx 1, then full-step reverse x3 (-6)
        HalfStep = 1'b1; Direction = 1'b0; Divider = 24'd2;
        push_steps(1, 2, 1'b1, 1'b1);
        pulse_start(16'd1);
        drain("to_idx1", 10);
        HalfStep = 1'b0; Direction = 1'b0;
        push_steps(3, 2, 1'b1, 1'b1);
        pulse_start(16'd3);
        drain("full_rev", 20);
        check("full_rev_pos", Position,  8'd3);
        check("full_rev_drv", StepDrive, 4'b0100);

        // Continuous run, half forward, period 3, coils released on stop
        Hold = 1'b0; HalfStep = 1'b1; Direction = 1'b1; Divider = 24'd3;
        StepEnable = 1'b1;
        push_steps(6, 3, 1'b0, 1'b0);
        cyc1();
        check("cont_not_busy", Busy, 1'b0);
        drain("cont", 30);
        StepEnable = 1'b0;
        cyc1();
        check("cont_stop_drv", StepDrive, 4'b0000);
        check("cont_stop_pos", Position,  m_pos);
        repeat (4) cyc1();
        check("cont_no_more_steps", Position, m_pos);
        Hold = 1'b1;
        cyc1();
        check("hold_on_drv", StepDrive, ptab(m_idx));

        // Abort on the edge where the 6th step would land
        Divider = 24'd2;
        push_steps(5, 2, 1'b1, 1'b0);
        pulse_start(16'd100);
        drain("abort_run", 20);
        cyc1();
        Abort = 1'b1;
        cyc1();
        Abort = 1'b0;
        check("abort_busy", Busy,     1'b0);
        check("abort_done", Done,     1'b0);
        check("abort_pos",  Position, 8'd14);
        repeat (4) begin
            cyc1();
            check("abort_idle_done", Done, 1'b0);
        end
        check("abort_idle_pos", Position, m_pos);

        // Start and StepEnable together: counted move wins
        StepEnable = 1'b1;
        push_steps(2, 2, 1'b1, 1'b1);
        pulse_start(16'd2);
        check("start_wins_busy", Busy, 1'b1);
        drain("start_wins", 12);
        StepEnable = 1'b0;
        cyc1();
        check("start_wins_idle", Busy,     1'b0);
        check("start_wins_pos",  Position, m_pos);

        // Divider 0 runs at period 2 (cycle checks in the drain)
        Divider = 24'd0; HalfStep = 1'b0; Direction = 1'b1;
        push_steps(3, 2, 1'b1, 1'b1);
        pulse_start(16'd3);
        drain("div0", 20);

        // Zero-length move: Done only
        pulse_start(16'd0);
        check("zero_done", Done,      1'b1);
        check("zero_busy", Busy,      1'b0);
        check("zero_pos",  Position,  m_pos);
        cyc1();
        check("zero_done_clr", Done,      1'b0);
        check("zero_drv",      StepDrive, ptab(m_idx));

        // Walk up to +127 then one half step to wrap to -128
        HalfStep = 1'b1; Direction = 1'b1; Divider = 24'd2;
        StepCount = {8'h00, 8'h7f - m_pos};
        push_steps(int'(StepCount), 2, 1'b1, 1'b1);
        pulse_start(StepCount);
        drain("to_127", 600);
        check("pos_127", Position, 8'h7f);
        push_steps(1, 2, 1'b1, 1'b1);
        pulse_start(16'd1);
        drain("wrap", 10);
        check("pos_wrap", Position, 8'h80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
